// File: rtl/bootrom_ahb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bootrom_ahb_ctrl
// Purpose  : AHB-Lite read-only slave in front of a synchronous ROM macro.
//            Reads that miss the single-entry last-word buffer access the
//            macro and wait RD_LAT-1 cycles. Reads that hit the buffer
//            complete with zero wait states. Writes get a two-cycle ERROR
//            response.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   AW       ROM word-address width (depth = 2^AW x 32-bit words)
//   RD_LAT   macro CLK-to-Q latency in cycles, 1..4
//   EMA      value driven on ROM_EMA
//   HIT_BUF  1 = last-word hit buffer present, 0 = every read hits the macro
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS  AHB address-phase controls (HADDR[AW+1:2] decoded)
//   HWRITE, HSIZE        write flag, size (ignored: full word returned)
//   HREADY               bus-wide ready input
//   HREADYOUT, HRESP     slave ready / response
//   HRDATA               read data, zero outside a completing read
//   ROM_CEN, ROM_A       macro chip enable (active-low) and word address
//   ROM_EMA              macro margin control
//   ROM_Q                macro read data
// ============================================================================
module bootrom_ahb_ctrl #(
  parameter int         AW      = 8,
  parameter int         RD_LAT  = 1,
  parameter logic [2:0] EMA     = 3'b010,
  parameter int         HIT_BUF = 1
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  output logic          ROM_CEN,
  output logic [AW-1:0] ROM_A,
  output logic [2:0]    ROM_EMA,
  input  logic [31:0]   ROM_Q
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_HIT  = 3'd2,
    ST_ERR1    = 3'd3,
    ST_ERR2    = 3'd4
  } state_t;

  // Wait-counter load value: number of stalled data-phase cycles of a miss.
  localparam logic [1:0] C_CNT_INIT = 2'(RD_LAT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_cnt;
  logic [1:0]    w_cnt_nxt;
  logic [AW-1:0] r_addr;        // word index of the transfer in data phase

  logic          w_accept;
  logic          w_done;        // current data phase (if any) ends this cycle
  logic          w_hit;
  logic          w_buf_load;
  logic [AW-1:0] w_idx;

  logic          w_buf_valid;
  logic [AW-1:0] w_buf_tag;
  logic [31:0]   w_buf_data;

  logic          w_hreadyout;
  logic          w_hresp;
  logic [31:0]   w_hrdata;

  // Size, the byte offset, the aliased upper address bits and HTRANS[0]
  // carry no information for a word-wide read-only ROM.
  logic          w_unused_inputs;
  assign w_unused_inputs = ^{HSIZE, HADDR[31:AW+2], HADDR[1:0], HTRANS[0]};

  assign w_idx    = HADDR[AW+1:2];
  assign w_accept = HSEL & HTRANS[1] & HREADY;
  assign w_hit    = w_buf_valid & (w_buf_tag == w_idx);

  // The macro is started straight from the address phase so that a
  // one-cycle macro returns data in the very next (data-phase) cycle.
  assign ROM_CEN  = ~(w_accept & w_done & ~HWRITE & ~w_hit);
  assign ROM_A    = w_idx;
  assign ROM_EMA  = EMA;

  assign HREADYOUT = w_hreadyout;
  assign HRESP     = w_hresp;
  assign HRDATA    = w_hrdata;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_done && w_accept) begin
        r_addr <= w_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and data-phase outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_cnt_nxt   = 2'd0;
    w_done      = 1'b1;
    w_buf_load  = 1'b0;
    w_hreadyout = 1'b1;
    w_hresp     = 1'b0;
    w_hrdata    = 32'd0;

    case (r_state)
      ST_IDLE: begin
        w_done = 1'b1;
      end
      ST_RD_WAIT: begin
        if (r_cnt != 2'd0) begin
          w_done      = 1'b0;
          w_hreadyout = 1'b0;
          w_state_nxt = ST_RD_WAIT;
          w_cnt_nxt   = r_cnt - 2'd1;
        end else begin
          w_hrdata   = ROM_Q;
          w_buf_load = 1'b1;
        end
      end
      ST_RD_HIT: begin
        w_hrdata = w_buf_data;
      end
      ST_ERR1: begin
        w_done      = 1'b0;
        w_hreadyout = 1'b0;
        w_hresp     = 1'b1;
        w_state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        w_hresp = 1'b1;
      end
      default: begin
        w_done = 1'b1;
      end
    endcase

    // A transfer accepted in the cycle that completes the previous one
    // starts immediately, giving back-to-back pipelined operation.
    if (w_done && w_accept) begin
      if (HWRITE) begin
        w_state_nxt = ST_ERR1;
      end else if (w_hit) begin
        w_state_nxt = ST_RD_HIT;
      end else begin
        w_state_nxt = ST_RD_WAIT;
        w_cnt_nxt   = C_CNT_INIT;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Last-word hit buffer. ROM contents never change, so a tag match always
  // returns correct data; the entry is only refreshed on miss completion.
  // --------------------------------------------------------------------------
  generate
    if (HIT_BUF != 0) begin : g_hit_buf
      logic          r_valid;
      logic [AW-1:0] r_tag;
      logic [31:0]   r_data;

      always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
          r_valid <= 1'b0;
          r_tag   <= '0;
          r_data  <= 32'd0;
        end else if (w_buf_load) begin
          r_valid <= 1'b1;
          r_tag   <= r_addr;
          r_data  <= ROM_Q;
        end
      end

      assign w_buf_valid = r_valid;
      assign w_buf_tag   = r_tag;
      assign w_buf_data  = r_data;
    end else begin : g_no_buf
      logic w_unused_buf;
      assign w_unused_buf = ^{r_addr, w_buf_load};
      assign w_buf_valid  = 1'b0;
      assign w_buf_tag    = '0;
      assign w_buf_data   = 32'd0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bootrom_ahb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bootrom_ahb_ctrl
// Purpose  : Self-checking bench for bootrom_ahb_ctrl. Four instances with
//            different RD_LAT / HIT_BUF settings sit on one AHB bus; the
//            bench selects one at a time. Each instance has a behavioural
//            ROM macro with the configured latency. Expected responses are
//            queued when a transfer is driven and compared when its data
//            phase completes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bootrom_ahb_ctrl;

  typedef struct {
    logic        wr;
    logic        miss;
    logic [7:0]  idx;
    logic [31:0] data;
    int          waits;
  } exp_t;

  localparam logic [31:0] C_JUNK = 32'hBAD0_BAD0;

  logic        clk;
  logic        rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready;
  int          sel;

  logic [3:0]  hro_v;
  logic [3:0]  hresp_v;
  logic [3:0]  cen_v;
  logic [31:0] hrdata_v [4];
  logic [7:0]  roma_v   [4];
  logic [2:0]  ema_v    [4];

  logic        s_hro;
  logic        s_hresp;
  logic        s_cen;
  logic [31:0] s_hrdata;
  logic [7:0]  s_roma;

  exp_t        q[$];
  logic        mvalid [4];
  logic [7:0]  mtag   [4];
  int          n_checks;
  int          n_fail;
  int          cen_cnt;
  logic        dp;
  int          wc;
  logic        acc;

  function automatic logic [31:0] romw(input logic [7:0] a);
    return {8'hC3, a, ~a, a ^ 8'h5A};
  endfunction

  function automatic int lat_of(input int s);
    return (s == 1) ? 3 : (s == 2) ? 4 : 1;
  endfunction

  function automatic logic hb_of(input int s);
    return (s != 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (sel=%0d t=%0t)", tag, obs, exp, sel, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign s_hro    = hro_v[sel];
  assign s_hresp  = hresp_v[sel];
  assign s_cen    = cen_v[sel];
  assign s_hrdata = hrdata_v[sel];
  assign s_roma   = roma_v[sel];
  assign hready   = s_hro;

  // --------------------------------------------------------------------------
  // DUT instances with their ROM macro models
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L  = (g == 1) ? 3 : (g == 2) ? 4 : 1;
    localparam int HB = (g == 3) ? 0 : 1;
    localparam int LI = (L >= 2) ? L - 2 : 0;

    logic        l_hsel;
    logic [31:0] romq;
    logic        sv [4];
    logic [7:0]  sa [4];

    assign l_hsel = hsel & (sel == g);

    // Q is valid exactly RD_LAT cycles after the CEN-low edge and is junk
    // otherwise, so sampling at the wrong time is visible.
    always @(posedge clk) begin
      if (!rst_n) begin
        romq <= C_JUNK;
        for (int k = 0; k < 4; k++) begin
          sv[k] <= 1'b0;
          sa[k] <= 8'd0;
        end
      end else begin
        if (L == 1) begin
          if (!cen_v[g]) romq <= romw(roma_v[g]);
          else           romq <= C_JUNK;
        end else begin
          if (sv[LI]) romq <= romw(sa[LI]);
          else        romq <= C_JUNK;
        end
        for (int k = 3; k > 0; k--) begin
          sv[k] <= sv[k-1];
          sa[k] <= sa[k-1];
        end
        sv[0] <= ~cen_v[g];
        sa[0] <= roma_v[g];
      end
    end

    bootrom_ahb_ctrl #(
      .AW      (8),
      .RD_LAT  (L),
      .EMA     (3'b010),
      .HIT_BUF (HB)
    ) u_dut (
      .HCLK      (clk),
      .HRESETn   (rst_n),
      .HSEL      (l_hsel),
      .HADDR     (haddr),
      .HTRANS    (htrans),
      .HWRITE    (hwrite),
      .HSIZE     (hsize),
      .HREADY    (hready),
      .HREADYOUT (hro_v[g]),
      .HRESP     (hresp_v[g]),
      .HRDATA    (hrdata_v[g]),
      .ROM_CEN   (cen_v[g]),
      .ROM_A     (roma_v[g]),
      .ROM_EMA   (ema_v[g]),
      .ROM_Q     (romq)
    );
  end

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_hreadyout", {31'd0, s_hro}, 32'd1);
      chk("rst_hresp", {31'd0, s_hresp}, 32'd0);
      chk("rst_hrdata", s_hrdata, 32'd0);
      chk("rst_cen", {31'd0, s_cen}, 32'd1);
      q.delete();
      dp = 1'b0;
      wc = 0;
      for (int k = 0; k < 4; k++) mvalid[k] = 1'b0;
    end else begin
      if (dp) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
          dp = 1'b0;
        end else if (!s_hro) begin
          wc++;
          chk("wait_hresp", {31'd0, s_hresp}, {31'd0, q[0].wr});
          chk("wait_hrdata", s_hrdata, 32'd0);
        end else begin
          chk("wait_cycles", wc, q[0].waits);
          chk("hresp", {31'd0, s_hresp}, {31'd0, q[0].wr});
          chk("hrdata", s_hrdata, q[0].data);
          if (!q[0].wr && q[0].miss && hb_of(sel)) begin
            mvalid[sel] = 1'b1;
            mtag[sel]   = q[0].idx;
          end
          void'(q.pop_front());
          dp = 1'b0;
        end
      end else begin
        chk("idle_hreadyout", {31'd0, s_hro}, 32'd1);
        chk("idle_hresp", {31'd0, s_hresp}, 32'd0);
        chk("idle_hrdata", s_hrdata, 32'd0);
      end

      acc = hsel & htrans[1] & s_hro;
      if (acc) begin
        if (q.size() == 0) begin
          chk("sb_missing", 32'd1, 32'd0);
        end else begin
          chk("addr_cen", {31'd0, s_cen}, {31'd0, ~q[$].miss});
          if (q[$].miss) chk("rom_a", {24'd0, s_roma}, {24'd0, q[$].idx});
        end
        dp = 1'b1;
        wc = 0;
      end else begin
        chk("idle_cen", {31'd0, s_cen}, 32'd1);
      end
      if (!s_cen) cen_cnt++;
    end
  end

  // --------------------------------------------------------------------------
  // Driver
  // --------------------------------------------------------------------------
  task automatic issue(input logic [31:0] a, input logic wr);
    exp_t e;
    int   b;
    e.wr    = wr;
    e.idx   = a[9:2];
    e.miss  = !wr && !(hb_of(sel) && mvalid[sel] && (mtag[sel] == a[9:2]));
    e.data  = wr ? 32'd0 : romw(a[9:2]);
    e.waits = wr ? 1 : (e.miss ? lat_of(sel) - 1 : 0);
    q.push_back(e);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = wr;
    b = 0;
    @(negedge clk);
    while (!hready && b < 20) begin
      b++;
      @(negedge clk);
    end
    chk("accept_timeout", (b < 20) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    #1;
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    hsel   = 1'b0;
    htrans = 2'b00;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int b;
    hsel   = 1'b0;
    htrans = 2'b00;
    b = 0;
    while (q.size() != 0 && b < 50) begin
      @(posedge clk);
      b++;
    end
    #1;
    chk("drain", q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    n_checks = 0;
    n_fail   = 0;
    cen_cnt  = 0;
    dp       = 1'b0;
    wc       = 0;
    sel      = 0;
    rst_n    = 1'b0;
    hsel     = 1'b0;
    htrans   = 2'b00;
    haddr    = 32'd0;
    hwrite   = 1'b0;
    hsize    = 3'b010;
    for (int k = 0; k < 4; k++) begin
      mvalid[k] = 1'b0;
      mtag[k]   = 8'd0;
    end

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    for (int k = 0; k < 4; k++) chk("rom_ema", {29'd0, ema_v[k]}, 32'd2);

    // RD_LAT=1: back-to-back misses, then a hit
    sel = 0;
    c = cen_cnt;
    issue(32'h0000_0010, 1'b0);
    issue(32'h0000_0014, 1'b0);
    idle(1);
    drain();
    chk("cen_b2b", cen_cnt - c, 32'd2);
    c = cen_cnt;
    issue(32'h0000_0014, 1'b0);
    drain();
    chk("cen_hit", cen_cnt - c, 32'd0);

    // BUSY with select: zero-wait OKAY, no macro access
    hsel = 1'b1; htrans = 2'b01; haddr = 32'h50;
    @(posedge clk); #1;
    idle(1);

    // Write error, then pipelined read of the same address
    issue(32'h0000_0040, 1'b1);
    issue(32'h0000_0040, 1'b0);
    idle(1);
    drain();

    // Wrap and aliasing
    issue(32'h0000_03FC, 1'b0);
    issue(32'h0000_0000, 1'b0);
    idle(1);
    c = cen_cnt;
    issue(32'h0000_0400, 1'b0);
    drain();
    chk("cen_alias_hit", cen_cnt - c, 32'd0);
    issue(32'hABCD_07FC, 1'b0);
    drain();

    // RD_LAT=3: miss with two wait states, then hit; pipelined misses
    sel = 1;
    idle(1);
    c = cen_cnt;
    issue(32'h0000_0020, 1'b0);
    drain();
    chk("cen_lat3_miss", cen_cnt - c, 32'd1);
    c = cen_cnt;
    issue(32'h0000_0020, 1'b0);
    drain();
    chk("cen_lat3_hit", cen_cnt - c, 32'd0);
    issue(32'h0000_0024, 1'b0);
    issue(32'h0000_0028, 1'b0);
    drain();

    // RD_LAT=4: reset in the middle of a wait abandons the transfer and
    // invalidates the buffer
    sel = 2;
    idle(1);
    issue(32'h0000_0030, 1'b0);
    drain();
    issue(32'h0000_0034, 1'b0);
    hsel = 1'b0; htrans = 2'b00;
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    c = cen_cnt;
    issue(32'h0000_0030, 1'b0);
    drain();
    chk("cen_after_reset", cen_cnt - c, 32'd1);

    // HIT_BUF=0: repeated reads always access the macro
    sel = 3;
    idle(1);
    c = cen_cnt;
    issue(32'h0000_0008, 1'b0);
    idle(1);
    issue(32'h0000_0008, 1'b0);
    drain();
    chk("cen_nobuf", cen_cnt - c, 32'd2);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
